// File: rtl/cell_draw_ctrl.sv
// cell_draw_ctrl: loads a cell X/Y from switches, bounds-checks them, then sweeps the cell's pixels.
// Optional erase input and latched colour are enabled by defining CELL_DRAW_ERASE_EN.
module cell_draw_ctrl #(
  parameter int COORD_W   = 8,
  parameter int CELL_LOG2 = 2,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         set,
  input  logic                         go,
`ifdef CELL_DRAW_ERASE_EN
  input  logic                         erase,
`endif
  input  logic [COORD_W-1:0]           coord_in,
  output logic [COORD_W+CELL_LOG2-1:0] pix_x,
  output logic [COORD_W+CELL_LOG2-1:0] pix_y,
  output logic                         write_en,
  output logic                         colour,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [2:0]                   state
);

  // CELL_LOG2=0 still needs a one-bit counter; it simply never leaves 0.
  localparam int CNT_W = (CELL_LOG2 > 0) ? 2 * CELL_LOG2 : 1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = (CELL_LOG2 > 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
  localparam logic [COORD_W:0]   GRID_W_L = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0]   GRID_H_L = (COORD_W + 1)'(GRID_H);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_X      = 3'd1,
    S_LOAD_X_WAIT = 3'd2,
    S_LOAD_Y      = 3'd3,
    S_ARMED       = 3'd4,
    S_DRAW        = 3'd5,
    S_DONE        = 3'd6,
    S_GO_REL      = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               x_ok_s, y_ok_s;

  // Unsigned compare with one extra bit so a grid of exactly 2^COORD_W cells is legal.
  assign x_ok_s = ({1'b0, coord_in} < GRID_W_L);
  assign y_ok_s = ({1'b0, coord_in} < GRID_H_L);

`ifdef CELL_DRAW_ERASE_EN
  logic erase_q, erase_d;
`endif

  // Register bank with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= {COORD_W{1'b0}};
      y_q     <= {COORD_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
`ifdef CELL_DRAW_ERASE_EN
      erase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CELL_DRAW_ERASE_EN
      erase_q <= erase_d;
`endif
    end
  end

  // Next-state, coordinate capture and pixel counter.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef CELL_DRAW_ERASE_EN
    erase_d = erase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (set) state_d = S_LOAD_X;
        else     state_d = S_IDLE;
      end
      S_LOAD_X: begin
        if (set) begin
          state_d = S_LOAD_X;
        end else if (x_ok_s) begin
          x_d     = coord_in;
          err_d   = 1'b0;
          state_d = S_LOAD_X_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOAD_X_WAIT: begin
        if (set) state_d = S_LOAD_Y;
        else     state_d = S_LOAD_X_WAIT;
      end
      S_LOAD_Y: begin
        if (set) begin
          state_d = S_LOAD_Y;
        end else if (y_ok_s) begin
          y_d     = coord_in;
          err_d   = 1'b0;
          state_d = S_ARMED;
        end else begin
          err_d   = 1'b1;
          state_d = S_LOAD_X_WAIT;
        end
      end
      S_ARMED: begin
        // go has priority over set so a simultaneous press draws.
        if (go) begin
          state_d = S_DRAW;
          cnt_d   = {CNT_W{1'b0}};
`ifdef CELL_DRAW_ERASE_EN
          erase_d = erase;
`endif
        end else if (set) begin
          state_d = S_LOAD_X;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_DRAW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_DRAW;
        end
      end
      S_DONE: begin
        state_d = S_GO_REL;
      end
      S_GO_REL: begin
        if (go) state_d = S_GO_REL;
        else    state_d = S_ARMED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  generate
    if (CELL_LOG2 > 0) begin : g_sub
      assign pix_x = {x_q, cnt_q[CELL_LOG2-1:0]};
      assign pix_y = {y_q, cnt_q[2*CELL_LOG2-1:CELL_LOG2]};
    end else begin : g_nosub
      assign pix_x = x_q;
      assign pix_y = y_q;
    end
  endgenerate

  assign write_en = (state_q == S_DRAW);
  assign busy     = (state_q == S_DRAW);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign state    = state_q;

`ifdef CELL_DRAW_ERASE_EN
  assign colour = ~erase_q;
`else
  assign colour = 1'b1;
`endif

endmodule
